// File: rtl/if_pkg.sv
// Shared types and sizes for the instruction fetch stage.
package if_pkg;

    localparam int IMEM_AW   = 10;
    localparam int BUF_DEPTH = 2;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_skid_fifo.sv
// Two-entry fetch buffer between the instruction memory and decode; flush empties it in one cycle.
module if_skid_fifo
    import if_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   occ
);

    fetch_entry_t entries [BUF_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; the top masks the head whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) entries[wr_ptr] <= push_data;
    end

    assign head = entries[rd_ptr];
    assign occ  = count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads, buffers returned instructions for decode.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module inst_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_dout,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [31:0]        if_instr,
    output logic [31:0]        if_pc,
    output logic               misalign_err
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);

    state_t       state;
    state_t       state_next;
    logic [31:0]  pc;
    logic [31:0]  inflight_pc;
    logic         inflight;
    logic         issue;
    logic         pop;
    logic         push;
    logic [1:0]   occ;
    logic [2:0]   demand;
    logic [2:0]   limit;
    fetch_entry_t head;
    fetch_entry_t capture;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Issuing on the entry cycle as well keeps first-valid latency at two cycles.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        demand     = {1'b0, occ} + {2'b00, inflight};
        limit      = 3'(BUF_DEPTH) + {2'b00, pop};
        case (state)
            S_IDLE:  if (fetch_en)  state_next = S_RUN;
            S_RUN:   if (!fetch_en) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (state_next == S_RUN && !redirect_valid && demand < limit) issue = 1'b1;
    end

    // A redirect wins over issue so the old-PC read is never started in the pulse cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc           <= RESET_PC;
            inflight     <= 1'b0;
            inflight_pc  <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) inflight_pc <= pc;
            if (redirect_valid) begin
                pc <= {redirect_pc[31:2], 2'b00};
                if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
            end else if (issue) begin
                pc <= pc + 32'd4;
            end
        end
    end

    assign imem_addr     = pc[IMEM_AW+1:2];
    assign pop           = if_valid & if_ready;
    assign push          = inflight & ~redirect_valid;
    assign capture.pc    = inflight_pc;
    assign capture.instr = imem_dout;

    if_skid_fifo u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (capture),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign if_valid = (occ != 2'd0);
    assign if_instr = if_valid ? head.instr : 32'd0;
    assign if_pc    = if_valid ? head.pc    : 32'd0;

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (pop)                  perf_fetched <= perf_fetched + 32'd1;
            if (if_valid && !if_ready) perf_stall  <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Table-driven bench for inst_fetch_unit with a registered-read 1K-word memory model.
// Build with IF_PERF_CNT_EN defined to also check the performance counters.
module tb_inst_fetch_unit;

    typedef struct {
        bit          rst;
        bit          en;
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        bit          ev;
        logic [31:0] epc;
        bit          emis;
        bit          ez;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_dout;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        misalign_err;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    logic [31:0] mem [1024];
    vec_t        vecs [$];
    int          n_applied;
    int          n_miss;
    int          exp_fetched;
    int          exp_stall;

    inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_dout      (imem_dout),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .misalign_err   (misalign_err)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memory: data for the sampled address appears one cycle later.
    initial imem_dout = 32'd0;
    always @(posedge clk) imem_dout <= mem[imem_addr];

    function automatic logic [31:0] word_of(input int i);
        if (i == 0)   return 32'h2011_0001;
        if (i == 1)   return 32'h0800_0C05;
        if (i == 256) return 32'h1631_0005;
        return 32'h5A00_0000 + 32'(i);
    endfunction

    function automatic vec_t mk(input bit rst, input bit en, input bit rdy, input bit rv,
                                input logic [31:0] rpc, input bit ev, input logic [31:0] epc,
                                input bit emis, input bit ez);
        vec_t v;
        v.rst = rst; v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.emis = emis; v.ez = ez;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset          = v.rst;
        fetch_en       = v.en;
        if_ready       = v.rdy;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
    endtask

    task automatic check_output(input vec_t v, input int idx);
        logic [31:0] ev_instr;
        cmp($sformatf("row%0d if_valid", idx), {31'd0, if_valid}, {31'd0, v.ev});
        cmp($sformatf("row%0d misalign_err", idx), {31'd0, misalign_err}, {31'd0, v.emis});
        if (v.ev) begin
            ev_instr = word_of(int'(v.epc[11:2]));
            cmp($sformatf("row%0d if_pc", idx), if_pc, v.epc);
            cmp($sformatf("row%0d if_instr", idx), if_instr, ev_instr);
        end else if (v.ez) begin
            cmp($sformatf("row%0d if_pc zero", idx), if_pc, 32'd0);
            cmp($sformatf("row%0d if_instr zero", idx), if_instr, 32'd0);
        end
    endtask

    initial begin
        n_applied   = 0;
        n_miss      = 0;
        exp_fetched = 0;
        exp_stall   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = word_of(i);

        // Cycle-by-cycle script: stream, stall, redirects, wrap, drain, reset with full buffer.
        vecs.push_back(mk(1,1,1,0,0,     0,32'h0,   0,0)); // c0
        vecs.push_back(mk(1,1,1,0,0,     0,32'h0,   0,0));
        vecs.push_back(mk(1,1,1,0,0,     1,32'h0,   0,0)); // c2 first valid
        vecs.push_back(mk(1,1,1,0,0,     1,32'h4,   0,0));
        vecs.push_back(mk(1,1,0,0,0,     1,32'h8,   0,0)); // c4 stall starts
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1,1,0,0,0, 1,32'h8, 0,0));
        vecs.push_back(mk(1,1,1,0,0,     1,32'h8,   0,0)); // c9 release
        vecs.push_back(mk(1,1,1,0,0,     1,32'hC,   0,0));
        vecs.push_back(mk(1,1,1,0,0,     1,32'h10,  0,0));
        vecs.push_back(mk(1,1,1,0,0,     1,32'h14,  0,0));
        vecs.push_back(mk(1,1,1,0,0,     1,32'h18,  0,0));
        vecs.push_back(mk(1,1,0,1,32'h400, 1,32'h1C, 0,0)); // c14 redirect, read in flight
        vecs.push_back(mk(1,1,1,0,0,     0,32'h0,   0,0));
        vecs.push_back(mk(1,1,1,0,0,     0,32'h0,   0,0));
        vecs.push_back(mk(1,1,1,0,0,     1,32'h400, 0,0));
        vecs.push_back(mk(1,1,1,0,0,     1,32'h404, 0,0));
        vecs.push_back(mk(1,1,0,0,0,     1,32'h408, 0,0));
        vecs.push_back(mk(1,1,0,1,32'h402, 1,32'h408, 0,0)); // c20 misaligned, buffer full
        vecs.push_back(mk(1,1,1,0,0,     0,32'h0,   1,0));
        vecs.push_back(mk(1,1,1,0,0,     0,32'h0,   1,0));
        vecs.push_back(mk(1,1,1,0,0,     1,32'h400, 1,0));
        vecs.push_back(mk(1,1,1,1,32'hFFC, 1,32'h404, 1,0)); // c24 redirect with pop
        vecs.push_back(mk(1,1,1,0,0,     0,32'h0,   1,0));
        vecs.push_back(mk(1,1,1,0,0,     0,32'h0,   1,0));
        vecs.push_back(mk(1,1,1,0,0,     1,32'hFFC, 1,0));
        vecs.push_back(mk(1,1,1,0,0,     1,32'h1000,1,0)); // aliases to word 0
        vecs.push_back(mk(1,0,1,0,0,     1,32'h1004,1,0)); // c29 fetch_en drops
        vecs.push_back(mk(1,0,1,0,0,     1,32'h1008,1,0)); // in-flight read drained
        vecs.push_back(mk(1,0,1,0,0,     0,32'h0,   1,0));
        vecs.push_back(mk(1,0,1,0,0,     0,32'h0,   1,0));
        vecs.push_back(mk(1,1,0,0,0,     0,32'h0,   1,0)); // c33 refill while stalled
        vecs.push_back(mk(1,1,0,0,0,     0,32'h0,   1,0));
        vecs.push_back(mk(1,1,0,0,0,     1,32'h100C,1,0));
        vecs.push_back(mk(1,1,0,0,0,     1,32'h100C,1,0)); // both entries full
        vecs.push_back(mk(0,1,0,0,0,     0,32'h0,   0,1)); // c37 reset asserted
        vecs.push_back(mk(1,1,1,0,0,     0,32'h0,   0,0));
        vecs.push_back(mk(1,1,1,0,0,     0,32'h0,   0,0));
        vecs.push_back(mk(1,1,1,0,0,     1,32'h0,   0,0)); // restart from RESET_PC
        vecs.push_back(mk(1,1,1,0,0,     1,32'h4,   0,0));
        vecs.push_back(mk(1,1,1,0,0,     1,32'h8,   0,0));

        // Power-on reset state.
        reset          = 1'b0;
        fetch_en       = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        cmp("reset if_valid", {31'd0, if_valid}, 32'd0);
        cmp("reset if_pc", if_pc, 32'd0);
        cmp("reset if_instr", if_instr, 32'd0);
        cmp("reset misalign_err", {31'd0, misalign_err}, 32'd0);
        cmp("reset imem_addr", {22'd0, imem_addr}, 32'd0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            #1;
            check_output(vecs[i], i);
            if (!vecs[i].rst) begin
                exp_fetched = 0;
                exp_stall   = 0;
            end else if (vecs[i].ev) begin
                if (vecs[i].rdy) exp_fetched++;
                else             exp_stall++;
            end
            @(posedge clk);
            #1;
        end

`ifdef IF_PERF_CNT_EN
        cmp("perf_fetched", perf_fetched, 32'(exp_fetched));
        cmp("perf_stall", perf_stall, 32'(exp_stall));
`endif

        // Reset asserted between clock edges must clear the visible entry at once.
        cmp("pre mid-cycle reset if_valid", {31'd0, if_valid}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        cmp("mid-cycle reset if_valid", {31'd0, if_valid}, 32'd0);
        cmp("mid-cycle reset if_pc", if_pc, 32'd0);
`ifdef IF_PERF_CNT_EN
        cmp("mid-cycle reset perf_fetched", perf_fetched, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        cmp("held reset if_valid", {31'd0, if_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
